register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb_pkg.sv | 13 +
 rtl/register_file_sb_reg_scoreboard.sv | 39 +++
 rtl/register_file_sb.sv | 134 +++++++++++++
 tb/tb_register_file_sb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package register_file_sb_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    function automatic logic addrInRange(input int addr, input int numRegs);
        return addr < numRegs;
    endfunction

endpackage

// File: rtl/register_file_sb_reg_scoreboard.sv
// Per-register pending-write bits: set by reservations, cleared by writes and the clear sweep.
module reg_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                set_en_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_en_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    input  logic                sweep_en_i,
    input  logic [ADDR_W-1:0]   sweep_addr_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set is applied last so a reservation beats a same-cycle write to that register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_en_i && clr_addr_i == ADDR_W'(i)) busy_d[i] = 1'b0;
            if (sweep_en_i && sweep_addr_i == ADDR_W'(i)) busy_d[i] = 1'b0;
            if (set_en_i && set_addr_i == ADDR_W'(i)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with write bypass, busy scoreboard and a bulk clear sweep.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    parameter  int OUT_REG  = NUM_REGS - 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                rd_valid_a,
    output logic                rd_valid_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ok,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [DATA_W-1:0]   output_reg_val
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    if (NUM_REGS < 2 || OUT_REG < 0 || OUT_REG >= NUM_REGS) begin : gBadParams
        $error("register_file_sb: need NUM_REGS >= 2 and 0 <= OUT_REG < NUM_REGS");
    end

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    clr_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              clrDone_q;

    logic wrAccept;
    logic inRangeA;
    logic inRangeB;
    logic hitA;
    logic hitB;

    assign clr_busy = (state_q == CLR_SWEEP);
    assign clr_done = clrDone_q;
    assign inRangeA = addrInRange(int'(rd_addr_a), NUM_REGS);
    assign inRangeB = addrInRange(int'(rd_addr_b), NUM_REGS);
    assign wrAccept = wr_en & ~clr_busy & addrInRange(int'(wr_addr), NUM_REGS);
    assign hitA     = wrAccept & (wr_addr == rd_addr_a);
    assign hitB     = wrAccept & (wr_addr == rd_addr_b);

    // Out-of-range addresses read as zero and are never valid; a same-cycle write bypasses.
    always_comb begin
        rd_data_a  = '0;
        rd_data_b  = '0;
        rd_valid_a = 1'b0;
        rd_valid_b = 1'b0;
        if (inRangeA) begin
            rd_data_a  = hitA ? wr_data : regs_q[rd_addr_a];
            rd_valid_a = ~clr_busy & (~busy_vec[rd_addr_a] | hitA);
        end
        if (inRangeB) begin
            rd_data_b  = hitB ? wr_data : regs_q[rd_addr_b];
            rd_valid_b = ~clr_busy & (~busy_vec[rd_addr_b] | hitB);
        end
    end

    // Reservation looks only at the registered busy bit.
    always_comb begin
        rsv_ok = 1'b0;
        if (rsv_en && !clr_busy && addrInRange(int'(rsv_addr), NUM_REGS)) begin
            rsv_ok = ~busy_vec[rsv_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (clr_busy) begin
            regs_q[cnt_q] <= '0;
        end else if (wrAccept) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= CLR_IDLE;
            cnt_q     <= '0;
            clrDone_q <= 1'b0;
        end else begin
            clrDone_q <= 1'b0;
            case (state_q)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state_q <= CLR_SWEEP;
                        cnt_q   <= '0;
                    end
                end
                CLR_SWEEP: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q   <= CLR_IDLE;
                        cnt_q     <= '0;
                        clrDone_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) uScoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .set_en_i     (rsv_ok),
        .set_addr_i   (rsv_addr),
        .clr_en_i     (wrAccept),
        .clr_addr_i   (wr_addr),
        .sweep_en_i   (clr_busy),
        .sweep_addr_i (cnt_q),
        .busy_vec_o   (busy_vec)
    );

    assign output_reg_val = regs_q[OUT_REG];

endmodule

// File: tb/tb_register_file_sb.sv
// Directed scoreboard bench for register_file_sb: an 8-register and a 6-register instance share stimulus.
module tb_register_file_sb;

    typedef enum int {
        OBS_RDA, OBS_VALA, OBS_RDB, OBS_VALB, OBS_RSVOK, OBS_CLRBUSY, OBS_CLRDONE,
        OBS_BUSY, OBS_OUTREG,
        OBS6_RDA, OBS6_VALA, OBS6_RDB, OBS6_VALB, OBS6_RSVOK, OBS6_CLRBUSY,
        OBS6_CLRDONE, OBS6_BUSY, OBS6_OUTREG
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetN;
    logic [2:0] rdAddrA, rdAddrB, wrAddr, rsvAddr;
    logic [7:0] wrData;
    logic       wrEn, rsvEn, clrReq;

    logic [7:0] rdDataA, rdDataB, outRegVal, busyVec;
    logic       rdValidA, rdValidB, rsvOk, clrBusy, clrDone;
    logic [7:0] rdDataA6, rdDataB6, outRegVal6;
    logic [5:0] busyVec6;
    logic       rdValidA6, rdValidB6, rsvOk6, clrBusy6, clrDone6;

    exp_t scoreQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clock = ~clock;

    register_file_sb #(.DATA_W(8), .NUM_REGS(8)) dut (
        .clock(clock), .reset_n(resetN),
        .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
        .rd_data_a(rdDataA), .rd_data_b(rdDataB),
        .rd_valid_a(rdValidA), .rd_valid_b(rdValidB),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ok(rsvOk),
        .clr_req(clrReq), .clr_busy(clrBusy), .clr_done(clrDone),
        .busy_vec(busyVec), .output_reg_val(outRegVal)
    );

    register_file_sb #(.DATA_W(8), .NUM_REGS(6)) dut6 (
        .clock(clock), .reset_n(resetN),
        .rd_addr_a(rdAddrA), .rd_addr_b(rdAddrB),
        .rd_data_a(rdDataA6), .rd_data_b(rdDataB6),
        .rd_valid_a(rdValidA6), .rd_valid_b(rdValidB6),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ok(rsvOk6),
        .clr_req(clrReq), .clr_busy(clrBusy6), .clr_done(clrDone6),
        .busy_vec(busyVec6), .output_reg_val(outRegVal6)
    );

    function automatic logic [31:0] observe(input obs_e sel);
        case (sel)
            OBS_RDA:      return {24'd0, rdDataA};
            OBS_VALA:     return {31'd0, rdValidA};
            OBS_RDB:      return {24'd0, rdDataB};
            OBS_VALB:     return {31'd0, rdValidB};
            OBS_RSVOK:    return {31'd0, rsvOk};
            OBS_CLRBUSY:  return {31'd0, clrBusy};
            OBS_CLRDONE:  return {31'd0, clrDone};
            OBS_BUSY:     return {24'd0, busyVec};
            OBS_OUTREG:   return {24'd0, outRegVal};
            OBS6_RDA:     return {24'd0, rdDataA6};
            OBS6_VALA:    return {31'd0, rdValidA6};
            OBS6_RDB:     return {24'd0, rdDataB6};
            OBS6_VALB:    return {31'd0, rdValidB6};
            OBS6_RSVOK:   return {31'd0, rsvOk6};
            OBS6_CLRBUSY: return {31'd0, clrBusy6};
            OBS6_CLRDONE: return {31'd0, clrDone6};
            OBS6_BUSY:    return {26'd0, busyVec6};
            default:      return {24'd0, outRegVal6};
        endcase
    endfunction

    task automatic pushExpect(input string tag, input obs_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        scoreQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                 input logic re, input logic [2:0] ra, input logic cr,
                                 input logic [2:0] aa, input logic [2:0] ab);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        rsvEn   = re;
        rsvAddr = ra;
        clrReq  = cr;
        rdAddrA = aa;
        rdAddrB = ab;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (scoreQ.size() > 0) begin
            e   = scoreQ.pop_front();
            obs = observe(e.sel);
            assertCount++;
            assert (obs === e.exp) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    initial begin
        // Reset must dominate a simultaneous write, reservation and clear request.
        resetN = 1'b0;
        applyStimulus(1'b1, 3'd3, 8'hAA, 1'b1, 3'd1, 1'b1, 3'd3, 3'd0);
        nextCycle();
        nextCycle();
        resetN = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd1);
        pushExpect("rst_busy", OBS_BUSY, 32'h0);
        pushExpect("rst_clrbusy", OBS_CLRBUSY, 32'h0);
        pushExpect("rst_clrdone", OBS_CLRDONE, 32'h0);
        pushExpect("rst_outreg", OBS_OUTREG, 32'h0);
        pushExpect("rst_rda", OBS_RDA, 32'h0);
        pushExpect("rst_vala", OBS_VALA, 32'h1);
        pushExpect("rst6_busy", OBS6_BUSY, 32'h0);
        checkOutput();
        nextCycle();

        // Plain write then read back, with bypass visible in the write cycle.
        applyStimulus(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 1'b0, 3'd3, 3'd0);
        pushExpect("wr_bypass_a", OBS_RDA, 32'h5A);
        pushExpect("wr_bypass_vala", OBS_VALA, 32'h1);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3);
        pushExpect("rd_r3_a", OBS_RDA, 32'h5A);
        pushExpect("rd_r3_vala", OBS_VALA, 32'h1);
        pushExpect("rd_r3_b", OBS_RDB, 32'h5A);
        checkOutput();
        nextCycle();

        // Reserve r2, refuse a second reservation, then release by writing.
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd2, 3'd0);
        pushExpect("rsv_r2_ok", OBS_RSVOK, 32'h1);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd2, 3'd0);
        pushExpect("rsv_r2_busy", OBS_BUSY, 32'h04);
        pushExpect("rsv_r2_vala", OBS_VALA, 32'h0);
        pushExpect("rersv_r2_ok", OBS_RSVOK, 32'h0);
        checkOutput();
        nextCycle();
        applyStimulus(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
        pushExpect("wr_busy_r2_a", OBS_RDA, 32'h11);
        pushExpect("wr_busy_r2_vala", OBS_VALA, 32'h1);
        pushExpect("wr_busy_r2_valb", OBS_VALB, 32'h1);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd2, 3'd0);
        pushExpect("r2_released_busy", OBS_BUSY, 32'h0);
        pushExpect("r2_released_a", OBS_RDA, 32'h11);
        checkOutput();
        nextCycle();

        // Write and reservation to r4 together: reservation wins the busy bit.
        applyStimulus(1'b1, 3'd4, 8'h77, 1'b1, 3'd4, 1'b0, 3'd4, 3'd0);
        pushExpect("wr_rsv_r4_ok", OBS_RSVOK, 32'h1);
        pushExpect("wr_rsv_r4_vala", OBS_VALA, 32'h1);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0);
        pushExpect("wr_rsv_r4_busy", OBS_BUSY, 32'h10);
        pushExpect("wr_rsv_r4_data", OBS_RDA, 32'h77);
        pushExpect("wr_rsv_r4_vala2", OBS_VALA, 32'h0);
        checkOutput();
        nextCycle();
        // A same-cycle write does not make a busy register reservable.
        applyStimulus(1'b1, 3'd4, 8'h78, 1'b1, 3'd4, 1'b0, 3'd4, 3'd0);
        pushExpect("rsv_busy_r4_ok", OBS_RSVOK, 32'h0);
        pushExpect("rsv_busy_r4_a", OBS_RDA, 32'h78);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4, 3'd0);
        pushExpect("r4_released_busy", OBS_BUSY, 32'h0);
        checkOutput();
        nextCycle();

        // Mirror output has no bypass and follows the write one cycle later.
        applyStimulus(1'b1, 3'd7, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        pushExpect("outreg_nobypass", OBS_OUTREG, 32'h0);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        pushExpect("outreg_3c", OBS_OUTREG, 32'h3C);
        checkOutput();

        // Fill everything, then sweep while writes and reservations are refused.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 3'd5, 8'h12, 1'b0, 3'd0, 1'b1, 3'd5, 3'd0);
        pushExpect("fill_outreg", OBS_OUTREG, 32'hFF);
        pushExpect("wr_with_clr_a", OBS_RDA, 32'h12);
        pushExpect("wr_with_clr_busy", OBS_CLRBUSY, 32'h0);
        checkOutput();
        nextCycle();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 3'd0, 8'h99, 1'b1, 3'd0, 1'b1, 3'd0, 3'd0);
            pushExpect("sweep_clrbusy", OBS_CLRBUSY, 32'h1);
            pushExpect("sweep_clrdone", OBS_CLRDONE, 32'h0);
            pushExpect("sweep_rsvok", OBS_RSVOK, 32'h0);
            pushExpect("sweep_vala", OBS_VALA, 32'h0);
            checkOutput();
            nextCycle();
        end
        // A request in the done cycle starts a fresh sweep.
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd5, 3'd0);
        pushExpect("done_pulse", OBS_CLRDONE, 32'h1);
        pushExpect("done_clrbusy", OBS_CLRBUSY, 32'h0);
        pushExpect("done_r5_zero", OBS_RDA, 32'h0);
        pushExpect("done_r0_zero", OBS_RDB, 32'h0);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            pushExpect("sweep2_clrbusy", OBS_CLRBUSY, 32'h1);
            pushExpect("sweep2_clrdone", OBS_CLRDONE, 32'h0);
            checkOutput();
            nextCycle();
        end
        pushExpect("done2_pulse", OBS_CLRDONE, 32'h1);
        checkOutput();
        nextCycle();
        pushExpect("done2_single", OBS_CLRDONE, 32'h0);
        pushExpect("after_sweep_busy", OBS_BUSY, 32'h0);
        pushExpect("after_sweep_outreg", OBS_OUTREG, 32'h0);
        checkOutput();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'(i), 3'(7 - i));
            pushExpect("cleared_a", OBS_RDA, 32'h0);
            pushExpect("cleared_vala", OBS_VALA, 32'h1);
            pushExpect("cleared_b", OBS_RDB, 32'h0);
            checkOutput();
            nextCycle();
        end

        // Six-register instance: out-of-range access and reset mid-sweep.
        resetN = 1'b0;
        nextCycle();
        resetN = 1'b1;
        applyStimulus(1'b1, 3'd7, 8'h55, 1'b1, 3'd7, 1'b0, 3'd7, 3'd6);
        pushExpect("oor_rda", OBS6_RDA, 32'h0);
        pushExpect("oor_vala", OBS6_VALA, 32'h0);
        pushExpect("oor_rdb", OBS6_RDB, 32'h0);
        pushExpect("oor_valb", OBS6_VALB, 32'h0);
        pushExpect("oor_rsvok", OBS6_RSVOK, 32'h0);
        checkOutput();
        nextCycle();
        applyStimulus(1'b1, 3'd5, 8'h21, 1'b1, 3'd1, 1'b0, 3'd5, 3'd7);
        pushExpect("oor_busy", OBS6_BUSY, 32'h0);
        pushExpect("oor_outreg", OBS6_OUTREG, 32'h0);
        pushExpect("r5_bypass6", OBS6_RDA, 32'h21);
        pushExpect("r5_val6", OBS6_VALA, 32'h1);
        pushExpect("rsv_r1_ok6", OBS6_RSVOK, 32'h1);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd7, 3'd0);
        pushExpect("outreg6_21", OBS6_OUTREG, 32'h21);
        pushExpect("busy6_r1", OBS6_BUSY, 32'h02);
        pushExpect("oor_rda_after", OBS6_RDA, 32'h0);
        checkOutput();
        nextCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0);
        pushExpect("sweep6_started", OBS6_CLRBUSY, 32'h1);
        checkOutput();
        nextCycle();
        nextCycle();
        resetN = 1'b0;
        applyStimulus(1'b1, 3'd5, 8'hEE, 1'b1, 3'd2, 1'b1, 3'd5, 3'd0);
        nextCycle();
        resetN = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0);
        pushExpect("abort6_clrbusy", OBS6_CLRBUSY, 32'h0);
        pushExpect("abort6_busy", OBS6_BUSY, 32'h0);
        pushExpect("abort6_outreg", OBS6_OUTREG, 32'h0);
        pushExpect("abort6_r5", OBS6_RDA, 32'h0);
        checkOutput();
        for (int k = 0; k < 8; k++) begin
            pushExpect("abort6_nodone", OBS6_CLRDONE, 32'h0);
            checkOutput();
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
